vga_fb_scheduler: RTL and testbench

Time-slot scheduler for the single-port framebuffer RAM shared between VGA scanout and a pixel writer (drawing engine / CPU). It runs on the 50 MHz system clock and consumes the pixel coordinates and pixel-rate tick from the sync generator. Each pixel period is split into two system-clock slots: the scanout slot reads the displayed pixel, and the other slot drains a 4-entry write FIFO. During blanking, every slot goes to the writer.

---
 rtl/vga_fb_scheduler.sv | 125 ++++++++++++
 tb/tb_vga_fb_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scheduler.sv
// Framebuffer RAM slot scheduler: scanout reads get the tick cycle, a 4-deep
// write FIFO drains in every other cycle (every cycle during blanking).
module vga_fb_scheduler #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_tick,
  input  logic [9:0]        x_pxl,
  input  logic [9:0]        y_pxl,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  output logic [2:0]        fifo_level,
  output logic              wr_drop
);

  localparam logic [9:0]        H_LIM = 10'(H_ACT);
  localparam logic [9:0]        V_LIM = 10'(V_ACT);
  localparam logic [ADDR_W-1:0] H_MUL = ADDR_W'(H_ACT);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * H_MUL + ADDR_W'(x);
  endfunction

  logic scan_slot;
  logic wr_fire;
  logic wr_on;
  logic push;
  logic pop;

  // Writer handshake: a transfer happens in any cycle with wr_valid & wr_ready;
  // wr_valid may be held, wr_ready depends only on the registered FIFO level.
  assign wr_ready  = (fifo_level < 3'd4);
  assign scan_slot = pix_tick && (x_pxl < H_LIM) && (y_pxl < V_LIM);
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_on     = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign push      = wr_fire && wr_on;
  assign pop       = !scan_slot && (fifo_level != 3'd0);

  logic [ADDR_W-1:0] q_addr [4];
  logic [DATA_W-1:0] q_data [4];
  logic [1:0]        wptr;
  logic [1:0]        rptr;

  // Storage needs no reset: the pointers and level define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wptr] <= pix_addr(wr_x, wr_y);
      q_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= 2'd0;
      rptr       <= 2'd0;
      fifo_level <= 3'd0;
      wr_drop    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 3'd1;
        2'b01:   fifo_level <= fifo_level - 3'd1;
        default: fifo_level <= fifo_level;
      endcase
      if (wr_fire && !wr_on) wr_drop <= 1'b1;
    end
  end

  // Scan always wins the port; the writer only ever takes non-scan cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (scan_slot) begin
      mem_addr <= pix_addr(x_pxl, y_pxl);
      mem_we   <= 1'b0;
    end else if (pop) begin
      mem_addr  <= q_addr[rptr];
      mem_wdata <= q_data[rptr];
      mem_we    <= 1'b1;
    end else begin
      mem_we <= 1'b0;
    end
  end

  logic s1_valid;
  logic s1_scan;
  logic s2_valid;
  logic s2_scan;

  // Two tag stages line the tick up with mem_rdata; blank ticks emit zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_scan     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_scan     <= 1'b0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      s1_valid    <= pix_tick;
      s1_scan     <= scan_slot;
      s2_valid    <= s1_valid;
      s2_scan     <= s1_scan;
      pixel_valid <= s2_valid;
      if (s2_valid) pixel_out <= s2_scan ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler with a behavioural RAM (1-cycle read).
module tb_vga_fb_scheduler;
  localparam int DW = 8;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pix_tick = 1'b0;
  logic [9:0]    x_pxl = 10'h3FF;
  logic [9:0]    y_pxl = 10'h3FF;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [9:0]    wr_x = 10'd0;
  logic [9:0]    wr_y = 10'd0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic [2:0]    fifo_level;
  logic          wr_drop;

  int total = 0;
  int bad = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_e;
  int  k;
  int  last_we;
  bit  saw_full;
  bit  scan_c;
  bit  hs;

  vga_fb_scheduler #(.H_ACT(640), .V_ACT(480), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .x_pxl(x_pxl), .y_pxl(y_pxl),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .fifo_level(fifo_level), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // RAM model: preset contents come from init_val until a location is written.
  bit [7:0] ram   [0:(1<<AW)-1];
  bit       wrote [0:(1<<AW)-1];

  function automatic bit [7:0] init_val(input logic [AW-1:0] a);
    if (a == 19'd0)      return 8'hA5;
    if (a == 19'd307199) return 8'h5A;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      wrote[mem_addr] <= 1'b1;
    end
    mem_rdata <= wrote[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y);
    pix_tick = 1'b1;
    x_pxl = x;
    y_pxl = y;
    step();
    pix_tick = 1'b0;
    x_pxl = 10'h3FF;
    y_pxl = 10'h3FF;
  endtask

  task automatic check_retire(input string tag);
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check({tag, "_spurious_we"}, mem_we, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check({tag, "_wr_addr"}, mem_addr, exp_e[AW+DW-1:DW]);
        check({tag, "_wr_data"}, mem_wdata, exp_e[DW-1:0]);
      end
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_pix"}, pixel_out, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_drop"}, wr_drop, 0);
    check({tag, "_ready"}, wr_ready, 1);
  endtask

  task automatic first_scan(input string tag);
    tick(10'd0, 10'd0);
    check({tag, "_addr_t1"}, mem_addr, 0);
    check({tag, "_we_t1"}, mem_we, 0);
    step();
    check({tag, "_pv_t2"}, pixel_valid, 0);
    step();
    check({tag, "_pix_t3"}, pixel_out, 8'hA5);
    check({tag, "_pv_t3"}, pixel_valid, 1);
    step();
    check({tag, "_pv_t4"}, pixel_valid, 0);
  endtask

  initial begin
    // Reset state.
    step();
    step();
    reset_outputs_zero("rst");
    rst = 1'b1;
    step();

    // First scan pixel: RAM[0]=A5.
    first_scan("scan0");

    // Last on-screen pixel, then a blank tick.
    tick(10'd639, 10'd479);
    check("scan_last_addr", mem_addr, 307199);
    step();
    step();
    check("scan_last_pix", pixel_out, 8'h5A);
    check("scan_last_pv", pixel_valid, 1);
    step();
    tick(10'h3FF, 10'd10);
    check("blank_no_we", mem_we, 0);
    check("blank_addr_hold", mem_addr, 307199);
    step();
    step();
    check("blank_pix", pixel_out, 0);
    check("blank_pv", pixel_valid, 1);
    step();
    tick(10'd5, 10'd480);
    check("blank_y480_addr_hold", mem_addr, 307199);
    step();
    step();
    check("blank_y480_pix", pixel_out, 0);
    step();

    // Single write into an empty FIFO with a free slot, then read it back.
    wr_valid = 1'b1; wr_x = 10'd7; wr_y = 10'd0; wr_data = 8'hC3;
    check("raw_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    check("raw_level1", fifo_level, 1);
    check("raw_no_we_t1", mem_we, 0);
    step();
    check("raw_we_t2", mem_we, 1);
    check("raw_addr_t2", mem_addr, 7);
    check("raw_data_t2", mem_wdata, 8'hC3);
    check("raw_level0", fifo_level, 0);
    tick(10'd7, 10'd0);
    check("raw_scan_addr", mem_addr, 7);
    step();
    step();
    check("raw_pix", pixel_out, 8'hC3);
    step();
    step();

    // Active video: ticks on odd cycles, writer holds valid for 8 writes.
    k = 0;
    last_we = -1;
    saw_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      scan_c = (c % 2 == 1);
      pix_tick = scan_c;
      x_pxl = 10'(c);
      y_pxl = 10'd5;
      wr_valid = (k < 8);
      wr_x = 10'(100 + k);
      wr_y = 10'd2;
      wr_data = 8'(16 + k);
      if (fifo_level == 3'd4) begin
        saw_full = 1'b1;
        check("act_ready_full", wr_ready, 0);
      end
      hs = wr_valid && wr_ready;
      if (hs) exp_q.push_back({19'(1380 + k), 8'(16 + k)});
      step();
      if (hs) k++;
      if (scan_c) begin
        check("act_scan_addr", mem_addr, 3200 + c);
        check("act_scan_we", mem_we, 0);
      end
      if (mem_we) begin
        if (last_we >= 0) check("act_wr_gap", c - last_we, 2);
        last_we = c;
      end
      check_retire("act");
    end
    pix_tick = 1'b0; x_pxl = 10'h3FF; y_pxl = 10'h3FF; wr_valid = 1'b0;
    check("act_saw_full", saw_full, 1);
    check("act_all_accepted", k, 8);
    check("act_all_retired", exp_q.size(), 0);
    step();
    step();
    step();

    // Fill to 4 during active video, then drain in blanking one per clk.
    for (int c = 0; c < 6; c++) begin
      pix_tick = (c % 2 == 1);
      x_pxl = 10'(c);
      y_pxl = 10'd6;
      wr_valid = 1'b1;
      wr_x = 10'(200 + c);
      wr_y = 10'd3;
      wr_data = 8'(8'h40 + c);
      check("fill_ready", wr_ready, 1);
      exp_q.push_back({19'(2120 + c), 8'(8'h40 + c)});
      step();
      check_retire("fill");
    end
    pix_tick = 1'b0; x_pxl = 10'h3FF; y_pxl = 10'h3FF; wr_valid = 1'b0;
    check("blank_level4", fifo_level, 4);
    check("blank_ready0", wr_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("blank_level", fifo_level, 3 - i);
      check("blank_we", mem_we, 1);
      check_retire("blank");
    end
    step();
    check("blank_we_done", mem_we, 0);
    check("blank_q_empty", exp_q.size(), 0);

    // Off-screen writes are accepted and dropped.
    wr_valid = 1'b1; wr_x = 10'd640; wr_y = 10'd0; wr_data = 8'hFF;
    check("drop_ready", wr_ready, 1);
    step();
    wr_x = 10'd0; wr_y = 10'd480;
    check("drop_flag", wr_drop, 1);
    check("drop_level_x", fifo_level, 0);
    step();
    wr_valid = 1'b0;
    check("drop_level_y", fifo_level, 0);
    check("drop_no_we", mem_we, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("drop_no_we_later", mem_we, 0);
      check("drop_sticky", wr_drop, 1);
    end

    // Reset with level 3 and a scan read in flight.
    for (int c = 0; c < 6; c++) begin
      pix_tick = (c % 2 == 1);
      x_pxl = (c == 5) ? 10'd20 : 10'(c);
      y_pxl = (c == 5) ? 10'd7 : 10'd8;
      wr_valid = (c < 5);
      wr_x = 10'(300 + c);
      wr_y = 10'd4;
      wr_data = 8'(8'h60 + c);
      if (c < 5) exp_q.push_back({19'(2860 + c), 8'(8'h60 + c)});
      step();
      check_retire("mid");
    end
    pix_tick = 1'b0; x_pxl = 10'h3FF; y_pxl = 10'h3FF; wr_valid = 1'b0;
    check("mid_level3", fifo_level, 3);
    check("mid_read_addr", mem_addr, 4500);
    check("mid_read_we", mem_we, 0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    reset_outputs_zero("mid_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_pv", pixel_valid, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_we", mem_we, 0);
      check("post_rst_pv", pixel_valid, 0);
      check("post_rst_level", fifo_level, 0);
    end
    first_scan("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
